channel_link_tx: RTL and testbench

Parametrised channel-link transmitter that drives the motherboard FIFO interface (DATAOUT, CHAN_LNK_CLK, MB_FIFO_PUSH_B, MOVLP, OVLPMUX, DATAAVAIL, ENDWORD) from a ready/valid sample stream. On each START request it frames one packet of NCHAN×NSAMP data words plus an optional XOR-checksum trailer. It emits one word per generated channel-link clock period and flags the last word with ENDWORD. It replaces the tied-off channel-link output stage at the top level, between the L1A readout buffer and the output pins.

---
 rtl/clnk_pkg.sv | 18 +
 rtl/channel_link_tx_if.sv | 35 +++
 rtl/clnk_clk_div.sv | 30 +++
 rtl/channel_link_tx.sv | 152 +++++++++++++++
 tb/tb_channel_link_tx.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/clnk_pkg.sv
// Shared types and helpers for the channel-link transmitter and its divider.
// Holds the FSM state encoding, the idle bus word and the word-counter width.
package clnk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        TRAIL = 2'd2,
        GAP   = 2'd3
    } clnk_state_t;

    localparam logic [127:0] IDLE_WORD = '0;

    function automatic int wcnt_width(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/channel_link_tx_if.sv
// Sample-stream, request and motherboard-FIFO signals of the channel-link transmitter.
// master = transmitter side, slave = readout buffer / pins side.
interface channel_link_tx_if #(
    parameter int DW = 16
);
    logic          START;
    logic          OVLP_TAG;
    logic          MUX_SEL;
    logic [DW-1:0] DIN;
    logic          DIN_VALID;
    logic          DIN_RDY;
    logic          CLR_ERR;
    logic [DW-1:0] DATAOUT;
    logic          CHAN_LNK_CLK;
    logic          MB_FIFO_PUSH_B;
    logic          MOVLP;
    logic          OVLPMUX;
    logic          DATAAVAIL;
    logic          ENDWORD;
    logic          BUSY;
    logic          UNDERRUN;
    logic          OVERFLOW;

    modport master (
        input  START, OVLP_TAG, MUX_SEL, DIN, DIN_VALID, CLR_ERR,
        output DIN_RDY, DATAOUT, CHAN_LNK_CLK, MB_FIFO_PUSH_B, MOVLP, OVLPMUX,
               DATAAVAIL, ENDWORD, BUSY, UNDERRUN, OVERFLOW
    );

    modport slave (
        output START, OVLP_TAG, MUX_SEL, DIN, DIN_VALID, CLR_ERR,
        input  DIN_RDY, DATAOUT, CHAN_LNK_CLK, MB_FIFO_PUSH_B, MOVLP, OVLPMUX,
               DATAAVAIL, ENDWORD, BUSY, UNDERRUN, OVERFLOW
    );
endinterface

// File: rtl/clnk_clk_div.sv
// Word-slot divider: free-running 0..CLK_DIV-1 counter, slot strobes and registered link clock.
// Latency: lnk_clk lags the counter by one cycle so its rising edge lands mid-word; no backpressure.
module clnk_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic slot_start,
    output logic slot_last,
    output logic lnk_clk
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            lnk_clk <= 1'b0;
        end else begin
            cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
            lnk_clk <= (cnt >= HALF);
        end
    end

    assign slot_start = (cnt == '0);
    assign slot_last  = (cnt == LAST);
endmodule

// File: rtl/channel_link_tx.sv
// Frames NCHAN*NSAMP stream words plus optional XOR trailer onto the motherboard FIFO, one word per slot.
// Latency: first push one CLK after the first slot start following START; a slot without DIN_VALID is skipped and retried.
module channel_link_tx
    import clnk_pkg::*;
#(
    parameter int DW        = 16,
    parameter int NCHAN     = 6,
    parameter int NSAMP     = 8,
    parameter int CLK_DIV   = 2,
    parameter int TRAILER   = 1,
    parameter int GAP_SLOTS = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    channel_link_tx_if.master    lnk
);
    localparam int NWORDS = NCHAN * NSAMP;
    localparam int WW     = wcnt_width(NWORDS);
    localparam int GW     = (GAP_SLOTS > 1) ? $clog2(GAP_SLOTS) : 1;
    localparam logic [WW-1:0] LAST_WORD = WW'(NWORDS - 1);
    localparam logic [GW-1:0] LAST_GAP  = GW'((GAP_SLOTS > 0) ? GAP_SLOTS - 1 : 0);
    localparam clnk_state_t   AFTER_PKT = (GAP_SLOTS > 0) ? GAP : IDLE;
    localparam logic [DW-1:0] IDLE_DAT  = IDLE_WORD[DW-1:0];

    logic slot_start, slot_last, lnk_clk;

    clnk_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk        (CLK),
        .rst        (RST),
        .slot_start (slot_start),
        .slot_last  (slot_last),
        .lnk_clk    (lnk_clk)
    );

    clnk_state_t   state, state_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic [DW-1:0] acc, acc_n, dout_q, dout_n;
    logic pend, pend_n, ptag, ptag_n, pmux, pmux_n;
    logic pushb_q, pushb_n, endw_q, endw_n, avail_q, avail_n;
    logic movlp_q, movlp_n, omux_q, omux_n, rdy_q, rdy_n, busy_q, busy_n;
    logic unr_q, unr_n, ovf_q, ovf_n;
    logic take, xfer, unr_set, ovf_set;

    always_comb begin
        state_n = state;    wcnt_n  = wcnt;    gcnt_n  = gcnt;    acc_n   = acc;
        pend_n  = pend;     ptag_n  = ptag;    pmux_n  = pmux;
        dout_n  = dout_q;   pushb_n = pushb_q; endw_n  = endw_q;  avail_n = avail_q;
        movlp_n = movlp_q;  omux_n  = omux_q;
        unr_set = 1'b0;
        take    = slot_start && (state == IDLE) && pend;
        xfer    = rdy_q && lnk.DIN_VALID;
        ovf_set = lnk.START && pend && !take;

        if (take) begin
            movlp_n = ptag;
            omux_n  = pmux;
            pend_n  = 1'b0;
        end
        // The pending slot frees up in the cycle it is taken, so a START there is kept
        if (lnk.START && (!pend || take)) begin
            pend_n = 1'b1;
            ptag_n = lnk.OVLP_TAG;
            pmux_n = lnk.MUX_SEL;
        end

        if (slot_start) begin
            dout_n  = IDLE_DAT;
            pushb_n = 1'b1;
            endw_n  = 1'b0;
            avail_n = 1'b0;
            unique case (state)
                IDLE, DATA: begin
                    if (state == DATA || pend) begin
                        state_n = DATA;
                        avail_n = 1'b1;
                        if (xfer) begin
                            dout_n  = lnk.DIN;
                            pushb_n = 1'b0;
                            acc_n   = acc ^ lnk.DIN;
                            if (wcnt == LAST_WORD) begin
                                wcnt_n = '0;
                                if (TRAILER != 0) begin
                                    state_n = TRAIL;
                                end else begin
                                    state_n = AFTER_PKT;
                                    endw_n  = 1'b1;
                                    acc_n   = '0;
                                end
                            end else begin
                                wcnt_n = wcnt + 1'b1;
                            end
                        end else begin
                            unr_set = 1'b1;
                        end
                    end
                end
                TRAIL: begin
                    dout_n  = acc;
                    pushb_n = 1'b0;
                    endw_n  = 1'b1;
                    avail_n = 1'b1;
                    acc_n   = '0;
                    state_n = AFTER_PKT;
                end
                GAP: begin
                    if (gcnt == LAST_GAP) begin
                        gcnt_n  = '0;
                        state_n = IDLE;
                    end else begin
                        gcnt_n = gcnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // DIN_RDY is registered, so it is decided one cycle ahead of the slot start
        rdy_n  = slot_last && ((state_n == DATA) || ((state_n == IDLE) && pend_n));
        busy_n = (state_n != IDLE) || pend_n;
        unr_n  = unr_set || (unr_q && !lnk.CLR_ERR);
        ovf_n  = ovf_set || (ovf_q && !lnk.CLR_ERR);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;   wcnt    <= '0;     gcnt    <= '0;     acc     <= '0;
            pend    <= 1'b0;   ptag    <= 1'b0;   pmux    <= 1'b0;
            dout_q  <= '0;     pushb_q <= 1'b1;   endw_q  <= 1'b0;   avail_q <= 1'b0;
            movlp_q <= 1'b0;   omux_q  <= 1'b0;   rdy_q   <= 1'b0;   busy_q  <= 1'b0;
            unr_q   <= 1'b0;   ovf_q   <= 1'b0;
        end else begin
            state   <= state_n;  wcnt    <= wcnt_n;   gcnt    <= gcnt_n;   acc     <= acc_n;
            pend    <= pend_n;   ptag    <= ptag_n;   pmux    <= pmux_n;
            dout_q  <= dout_n;   pushb_q <= pushb_n;  endw_q  <= endw_n;   avail_q <= avail_n;
            movlp_q <= movlp_n;  omux_q  <= omux_n;   rdy_q   <= rdy_n;    busy_q  <= busy_n;
            unr_q   <= unr_n;    ovf_q   <= ovf_n;
        end
    end

    assign lnk.DIN_RDY        = rdy_q;
    assign lnk.DATAOUT        = dout_q;
    assign lnk.CHAN_LNK_CLK   = lnk_clk;
    assign lnk.MB_FIFO_PUSH_B = pushb_q;
    assign lnk.MOVLP          = movlp_q;
    assign lnk.OVLPMUX        = omux_q;
    assign lnk.DATAAVAIL      = avail_q;
    assign lnk.ENDWORD        = endw_q;
    assign lnk.BUSY           = busy_q;
    assign lnk.UNDERRUN       = unr_q;
    assign lnk.OVERFLOW       = ovf_q;
endmodule

// File: tb/tb_channel_link_tx.sv
// Directed bench: a 2x2-word packet link at CLK_DIV=2 plus a CLK_DIV=4 instance for link-clock timing.
module tb_channel_link_tx;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    channel_link_tx_if #(.DW(16)) lnk ();
    channel_link_tx_if #(.DW(16)) lnk4 ();

    channel_link_tx #(.DW(16), .NCHAN(2), .NSAMP(2), .CLK_DIV(2), .TRAILER(1), .GAP_SLOTS(1)) dut (
        .CLK(CLK), .RST(RST), .lnk(lnk.master));
    channel_link_tx #(.DW(16), .NCHAN(2), .NSAMP(2), .CLK_DIV(4), .TRAILER(1), .GAP_SLOTS(1)) dut4 (
        .CLK(CLK), .RST(RST), .lnk(lnk4.master));

    typedef struct packed {
        logic        push_b;
        logic [15:0] data;
        logic        endw;
        logic        avail;
        logic        movlp;
        logic        mux;
    } slot_t;

    int checks = 0;
    int failures = 0;
    int m2 = 0;
    int m4 = 0;
    int popped = 0;
    int skip_idx = -1;
    bit skipped = 1'b0;
    logic [15:0] q[$];
    slot_t slog[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        if (q.size() > 0) lnk.DIN = q[0];
        else lnk.DIN = 16'h0000;
        lnk.DIN_VALID = (q.size() > 0) && !((popped == skip_idx) && !skipped);
    endtask

    task automatic step();
        bit hs;
        hs = lnk.DIN_RDY && lnk.DIN_VALID;
        if (lnk.DIN_RDY && !lnk.DIN_VALID && (popped == skip_idx)) skipped = 1'b1;
        @(posedge CLK);
        #1;
        m2 = (m2 + 1) % 2;
        m4 = (m4 + 1) % 4;
        if (hs && q.size() > 0) begin
            void'(q.pop_front());
            popped++;
        end
        drive();
        if (m2 == 1) begin
            slot_t s;
            s.push_b = lnk.MB_FIFO_PUSH_B;
            s.data   = lnk.DATAOUT;
            s.endw   = lnk.ENDWORD;
            s.avail  = lnk.DATAAVAIL;
            s.movlp  = lnk.MOVLP;
            s.mux    = lnk.OVLPMUX;
            slog.push_back(s);
        end
    endtask

    // Word-slot record check; data is only meaningful on push slots
    task automatic chk_slot(input string t, input int i, input logic pb, input logic [15:0] d,
                            input logic e, input logic av, input logic mv, input logic mx);
        slot_t s, x;
        if (i < slog.size()) s = slog[i];
        else s = '1;
        x.push_b = pb;
        x.data   = pb ? s.data : d;
        x.endw   = e;
        x.avail  = av;
        x.movlp  = mv;
        x.mux    = mx;
        chk($sformatf("%s_slot%0d", t, i), 32'(s), 32'(x));
    endtask

    task automatic chk_rst(input string t);
        chk({t, "_dataout"}, 32'(lnk.DATAOUT), 32'h0);
        chk({t, "_clk"},     32'(lnk.CHAN_LNK_CLK), 32'h0);
        chk({t, "_push_b"},  32'(lnk.MB_FIFO_PUSH_B), 32'h1);
        chk({t, "_movlp"},   32'(lnk.MOVLP), 32'h0);
        chk({t, "_ovlpmux"}, 32'(lnk.OVLPMUX), 32'h0);
        chk({t, "_avail"},   32'(lnk.DATAAVAIL), 32'h0);
        chk({t, "_endword"}, 32'(lnk.ENDWORD), 32'h0);
        chk({t, "_din_rdy"}, 32'(lnk.DIN_RDY), 32'h0);
        chk({t, "_busy"},    32'(lnk.BUSY), 32'h0);
        chk({t, "_underrun"},32'(lnk.UNDERRUN), 32'h0);
        chk({t, "_overflow"},32'(lnk.OVERFLOW), 32'h0);
    endtask

    task automatic align();
        if (m2 != 1) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        lnk.START = 0; lnk.OVLP_TAG = 0; lnk.MUX_SEL = 0; lnk.CLR_ERR = 0;
        lnk.DIN = 0; lnk.DIN_VALID = 0;
        lnk4.START = 0; lnk4.OVLP_TAG = 0; lnk4.MUX_SEL = 0; lnk4.CLR_ERR = 0;
        lnk4.DIN = 16'h00AB; lnk4.DIN_VALID = 1;
        #1 RST = 1;
        #11;
        chk_rst("reset");
        RST = 0;
        m2 = 0; m4 = 0;

        // Basic packet: 4 words, trailer 0xFFFF
        q = '{16'h1111, 16'h2222, 16'h4444, 16'h8888};
        popped = 0; drive(); align();
        slog.delete();
        lnk.START = 1; step(); lnk.START = 0;
        chk("t1_rdy_take", 32'(lnk.DIN_RDY), 32'h1);
        chk("t1_busy", 32'(lnk.BUSY), 32'h1);
        chk("t1_no_push_yet", 32'(lnk.MB_FIFO_PUSH_B), 32'h1);
        repeat (13) step();
        chk_slot("t1", 0, 0, 16'h1111, 0, 1, 0, 0);
        chk_slot("t1", 1, 0, 16'h2222, 0, 1, 0, 0);
        chk_slot("t1", 2, 0, 16'h4444, 0, 1, 0, 0);
        chk_slot("t1", 3, 0, 16'h8888, 0, 1, 0, 0);
        chk_slot("t1", 4, 0, 16'hFFFF, 1, 1, 0, 0);
        chk_slot("t1", 5, 1, 16'h0000, 0, 0, 0, 0);
        chk_slot("t1", 6, 1, 16'h0000, 0, 0, 0, 0);
        chk("t1_underrun", 32'(lnk.UNDERRUN), 32'h0);
        chk("t1_busy_end", 32'(lnk.BUSY), 32'h0);

        // Underrun on the second word's slot
        q = '{16'h1111, 16'h2222, 16'h4444, 16'h8888};
        popped = 0; skip_idx = 1; skipped = 0; drive(); align();
        slog.delete();
        lnk.START = 1; step(); lnk.START = 0;
        repeat (15) step();
        chk_slot("t2", 0, 0, 16'h1111, 0, 1, 0, 0);
        chk_slot("t2", 1, 1, 16'h0000, 0, 1, 0, 0);
        chk_slot("t2", 2, 0, 16'h2222, 0, 1, 0, 0);
        chk_slot("t2", 3, 0, 16'h4444, 0, 1, 0, 0);
        chk_slot("t2", 4, 0, 16'h8888, 0, 1, 0, 0);
        chk_slot("t2", 5, 0, 16'hFFFF, 1, 1, 0, 0);
        chk_slot("t2", 6, 1, 16'h0000, 0, 0, 0, 0);
        chk("t2_underrun_set", 32'(lnk.UNDERRUN), 32'h1);
        lnk.CLR_ERR = 1; step(); lnk.CLR_ERR = 0;
        chk("t2_underrun_clr", 32'(lnk.UNDERRUN), 32'h0);
        skip_idx = -1;

        // Three STARTs in one packet, tags 1/1 then 0/0
        q = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080};
        popped = 0; drive(); align();
        slog.delete();
        lnk.START = 1; lnk.OVLP_TAG = 1; lnk.MUX_SEL = 1;
        step();
        lnk.START = 0; lnk.OVLP_TAG = 0; lnk.MUX_SEL = 0;
        repeat (3) step();
        lnk.START = 1; step(); lnk.START = 0;
        repeat (2) step();
        chk("t3_overflow_before", 32'(lnk.OVERFLOW), 32'h0);
        lnk.START = 1; step(); lnk.START = 0;
        chk("t3_overflow_set", 32'(lnk.OVERFLOW), 32'h1);
        chk("t3_busy", 32'(lnk.BUSY), 32'h1);
        repeat (18) step();
        chk_slot("t3", 0, 0, 16'h0001, 0, 1, 1, 1);
        chk_slot("t3", 1, 0, 16'h0002, 0, 1, 1, 1);
        chk_slot("t3", 2, 0, 16'h0004, 0, 1, 1, 1);
        chk_slot("t3", 3, 0, 16'h0008, 0, 1, 1, 1);
        chk_slot("t3", 4, 0, 16'h000F, 1, 1, 1, 1);
        chk_slot("t3", 5, 1, 16'h0000, 0, 0, 1, 1);
        chk_slot("t3", 6, 0, 16'h0010, 0, 1, 0, 0);
        chk_slot("t3", 7, 0, 16'h0020, 0, 1, 0, 0);
        chk_slot("t3", 8, 0, 16'h0040, 0, 1, 0, 0);
        chk_slot("t3", 9, 0, 16'h0080, 0, 1, 0, 0);
        chk_slot("t3", 10, 0, 16'h00F0, 1, 1, 0, 0);
        chk_slot("t3", 11, 1, 16'h0000, 0, 0, 0, 0);
        chk_slot("t3", 12, 1, 16'h0000, 0, 0, 0, 0);
        chk("t3_busy_end", 32'(lnk.BUSY), 32'h0);
        lnk.CLR_ERR = 1; step(); lnk.CLR_ERR = 0;
        chk("t3_overflow_clr", 32'(lnk.OVERFLOW), 32'h0);

        // CLK_DIV=4: word holds 4 cycles, link clock 0,0,1,1 across the word
        while (m4 != 1) step();
        lnk4.START = 1; step(); lnk4.START = 0;
        step();
        step();
        chk("t4_rdy", 32'(lnk4.DIN_RDY), 32'h1);
        chk("t4_no_push_yet", 32'(lnk4.MB_FIFO_PUSH_B), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t4_push_c%0d", i), 32'(lnk4.MB_FIFO_PUSH_B), 32'h0);
            chk($sformatf("t4_data_c%0d", i), 32'(lnk4.DATAOUT), 32'h00AB);
            chk($sformatf("t4_clk_c%0d", i), 32'(lnk4.CHAN_LNK_CLK), (i >= 2) ? 32'h1 : 32'h0);
        end
        repeat (24) step();

        // Reset mid-DATA, then a fresh packet with restarted checksum
        q = '{16'h1111, 16'h2222, 16'h4444, 16'h8888};
        popped = 0; drive(); align();
        lnk.START = 1; lnk.OVLP_TAG = 1; step(); lnk.START = 0; lnk.OVLP_TAG = 0;
        repeat (3) step();
        chk("t5_pre_push", 32'(lnk.MB_FIFO_PUSH_B), 32'h0);
        chk("t5_pre_movlp", 32'(lnk.MOVLP), 32'h1);
        #2 RST = 1;
        #1 chk_rst("t5_rst");
        #1 RST = 0;
        m2 = 0; m4 = 0;
        q.delete();
        q = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        popped = 0; drive(); align();
        slog.delete();
        lnk.START = 1; step(); lnk.START = 0;
        repeat (11) step();
        chk_slot("t5", 0, 0, 16'h0101, 0, 1, 0, 0);
        chk_slot("t5", 1, 0, 16'h0202, 0, 1, 0, 0);
        chk_slot("t5", 2, 0, 16'h0303, 0, 1, 0, 0);
        chk_slot("t5", 3, 0, 16'h0404, 0, 1, 0, 0);
        chk_slot("t5", 4, 0, 16'h0404, 1, 1, 0, 0);
        chk_slot("t5", 5, 1, 16'h0000, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
